// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader.
//
// Receives a byte stream (4-byte little-endian word count N, N little-endian
// 32-bit instruction words, 1 XOR checksum byte) and writes each assembled
// word to consecutive word addresses starting at base_addr. The CPU is held
// in reset (cpu_rst_n=0) until a complete image with a matching checksum has
// been written.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_valid may drop at any time and simply stalls the loader; in_ready is a
// pure function of state (and rst) and never depends on in_valid. The memory
// write port has no backpressure, so in_ready stays high throughout DATA.
//
// dbg_state exposes the FSM state encoding for observation only.

module imem_loader #(
    parameter int                    addr_width = 32,
    parameter int                    data_width = 32,
    parameter logic [addr_width-1:0] base_addr  = '0,
    parameter int                    max_words  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  wr_en,
    output logic [addr_width-1:0] wr_addr,
    output logic [data_width-1:0] wr_data,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_DATA  = 3'd1,
        S_CSUM  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            byte_cnt;
    logic [31:0]           word_cnt;
    logic [31:0]           count_n;
    logic [23:0]           word_sh;
    logic [7:0]            run_xor;
    logic [addr_width-1:0] next_addr;

    logic                  accept;
    logic                  last_byte;
    logic                  issue_write;
    logic                  enter_count;
    logic [31:0]           count_full;
    logic [31:0]           word_full;

    // The count and the word shift in LSB first, so the value completed by
    // the current byte is the incoming byte on top of the bytes held so far.
    assign count_full = {in_data, count_n[31:8]};
    assign word_full  = {in_data, word_sh};
    assign accept     = in_valid && in_ready;
    assign last_byte  = (byte_cnt == 2'd3);
    assign dbg_state  = state;

    // Ready whenever the loader is consuming stream bytes; forced low in reset.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CSUM);
        end
    end

    // Next-state logic plus the per-cycle write and re-arm decisions.
    always_comb begin
        state_next  = state;
        issue_write = 1'b0;
        enter_count = 1'b0;
        case (state)
            S_COUNT: begin
                if (accept && last_byte) begin
                    if (count_full > 32'(max_words)) begin
                        state_next = S_ERR;
                    end else if (count_full == 32'd0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && last_byte) begin
                    issue_write = 1'b1;
                    if ((word_cnt + 32'd1) == count_n) begin
                        state_next = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (in_data == run_xor) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_next  = S_COUNT;
                    enter_count = 1'b1;
                end
            end
            default: begin
                state_next = S_COUNT;
            end
        endcase
    end

    // State register; status outputs are registered from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_COUNT;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_rst_n <= 1'b0;
            wr_en     <= 1'b0;
        end else begin
            state     <= state_next;
            done      <= (state_next == S_DONE);
            error     <= (state_next == S_ERR);
            cpu_rst_n <= (state_next == S_DONE);
            wr_en     <= issue_write;
        end
    end

    // Datapath: byte assembly, running checksum, counters and write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= 2'd0;
            word_cnt  <= 32'd0;
            count_n   <= 32'd0;
            word_sh   <= 24'd0;
            run_xor   <= 8'd0;
            next_addr <= base_addr;
            wr_addr   <= base_addr;
            wr_data   <= '0;
        end else if (enter_count) begin
            byte_cnt  <= 2'd0;
            word_cnt  <= 32'd0;
            count_n   <= 32'd0;
            word_sh   <= 24'd0;
            run_xor   <= 8'd0;
            next_addr <= base_addr;
        end else if (accept) begin
            run_xor  <= run_xor ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == S_COUNT) begin
                count_n <= count_full;
            end
            if (state == S_DATA) begin
                word_sh <= word_full[31:8];
                if (last_byte) begin
                    word_cnt  <= word_cnt + 32'd1;
                    next_addr <= next_addr + addr_width'(4);
                    wr_addr   <= next_addr;
                    wr_data   <= word_full;
                end
            end
        end
    end

endmodule
